// File: rtl/vm_pkg.sv
// ---------------------------------------------------------------------------
// vm_pkg
// Shared definitions for the vending-machine money path (cash input,
// transaction, change dispenser).
//   D0..D5   : denomination values in jiao
//   SEL_D0.. : one-hot bit for each denomination (bit k <-> Dk)
//   state_t  : change dispenser FSM states
// ---------------------------------------------------------------------------
package vm_pkg;

    localparam logic [11:0] D5 = 12'd500;
    localparam logic [11:0] D4 = 12'd200;
    localparam logic [11:0] D3 = 12'd100;
    localparam logic [11:0] D2 = 12'd50;
    localparam logic [11:0] D1 = 12'd10;
    localparam logic [11:0] D0 = 12'd5;

    localparam logic [5:0] SEL_D5 = 6'b100000;
    localparam logic [5:0] SEL_D4 = 6'b010000;
    localparam logic [5:0] SEL_D3 = 6'b001000;
    localparam logic [5:0] SEL_D2 = 6'b000100;
    localparam logic [5:0] SEL_D1 = 6'b000010;
    localparam logic [5:0] SEL_D0 = 6'b000001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_REQ,
        ST_GAP,
        ST_DONE,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/coin_pick.sv
// ---------------------------------------------------------------------------
// coin_pick
// Combinational priority picker: largest denomination not exceeding remain.
//   remain [11:0] in  : amount still owed (jiao)
//   sel    [5:0]  out : one-hot denomination, 0 when remain < D0
//   value  [11:0] out : value of the selected denomination, 0 when none
// ---------------------------------------------------------------------------
module coin_pick
    import vm_pkg::*;
(
    input  logic [11:0] remain,
    output logic [5:0]  sel,
    output logic [11:0] value
);

    always_comb begin
        sel   = '0;
        value = '0;
        if (remain >= D5) begin
            sel   = SEL_D5;
            value = D5;
        end else if (remain >= D4) begin
            sel   = SEL_D4;
            value = D4;
        end else if (remain >= D3) begin
            sel   = SEL_D3;
            value = D3;
        end else if (remain >= D2) begin
            sel   = SEL_D2;
            value = D2;
        end else if (remain >= D1) begin
            sel   = SEL_D1;
            value = D1;
        end else if (remain >= D0) begin
            sel   = SEL_D0;
            value = D0;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Pays out a change amount one piece at a time through a req/ack hopper,
// always choosing the largest denomination that fits.
//   clk, rst          : clock, asynchronous active-high reset
//   start, amount     : one-cycle start pulse, amount in jiao sampled on it
//   coin_req/coin_ack : hopper handshake; coin_sel one-hot, held during req
//   clear             : leaves FAULT
//   busy, done, fault : status (done is a one-cycle pulse)
//   remain, residue   : amount still owed, unpayable remainder (< D0)
//   coin_count        : pieces paid this payout (saturating)
// ---------------------------------------------------------------------------
module change_dispenser
    import vm_pkg::*;
#(
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] amount,
    input  logic        coin_ack,
    input  logic        clear,
    output logic        coin_req,
    output logic [5:0]  coin_sel,
    output logic        busy,
    output logic        done,
    output logic [11:0] remain,
    output logic [11:0] residue,
    output logic [7:0]  coin_count,
    output logic        fault
);

    // One counter serves both the ack timeout (REQ) and the hopper gap (GAP).
    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    state_t            state_q,   state_d;
    logic [11:0]       remain_q,  remain_d;
    logic [11:0]       residue_q, residue_d;
    logic [7:0]        count_q,   count_d;
    logic [5:0]        sel_q,     sel_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic [5:0]        pick_sel;
    logic [11:0]       pick_val;

    coin_pick u_pick (
        .remain (remain_q),
        .sel    (pick_sel),
        .value  (pick_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            remain_q  <= '0;
            residue_q <= '0;
            count_q   <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            residue_q <= residue_d;
            count_q   <= count_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        residue_d = residue_q;
        count_d   = count_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remain_d  = amount;
                    count_d   = '0;
                    residue_d = '0;
                    state_d   = ST_SELECT;
                end
            end

            ST_SELECT: begin
                // No denomination fits: whatever is left (possibly 0) is residue.
                if (pick_sel == '0) begin
                    residue_d = remain_q;
                    state_d   = ST_DONE;
                end else begin
                    sel_d   = pick_sel;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                // remain_q is unchanged during REQ, so pick_val still matches sel_q.
                if (coin_ack) begin
                    remain_d = remain_q - pick_val;
                    count_d  = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    sel_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_GAP;
                end else if (cnt_q == TMO_LAST) begin
                    sel_d   = '0;
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_SELECT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            ST_FAULT: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign coin_req   = (state_q == ST_REQ);
    assign coin_sel   = sel_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign fault      = (state_q == ST_FAULT);
    assign remain     = remain_q;
    assign residue    = residue_q;
    assign coin_count = count_q;

endmodule
